operand_fetch_stage: RTL
========================

Name: operand_fetch_stage

Overview:
- Decode/register-read stage directly upstream of the ALU.
- Takes a 32-bit RV64I instruction and holds the 32x64 integer register file. Produces a registered ALU bundle (`alu_op`, `data_1`, `data_2`) plus destination and memory-control sideband.
- One-entry output register with valid/ready handshake. Accepts writeback from the end of the datapath.

Parameters:
- XLEN, 64, data/register width
- NREGS, 32, register count (address width 5)

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high
- in_valid  input  1  instr is valid
- in_ready  output  1  stage can accept instr this cycle
- instr  input  32  RV64I instruction word
- wb_en  input  1  register-file write enable
- wb_addr  input  5  writeback register index
- wb_data  input  XLEN  writeback value
- out_valid  output  1  output bundle valid
- out_ready  input  1  downstream consumes bundle
- alu_op  output  2  00 add, 01 sub, 10 or, 11 and
- data_1  output  XLEN  ALU operand 1 (rs1 value)
- data_2  output  XLEN  ALU operand 2 (rs2 value or sign-extended immediate)
- store_data  output  XLEN  rs2 value for stores
- rd_addr  output  5  destination register
- reg_write  output  1  instruction writes rd
- mem_read  output  1  load
- mem_write  output  1  store
- is_branch  output  1  beq; equal when ALU result is zero
- illegal  output  1  unsupported encoding accepted

Behaviour:
- Reset (synchronous, active-high): all 32 registers = 0; out_valid = 0; all bundle outputs = 0.
  - Reset has priority over acceptance and writeback in the same cycle.
  - Reset asserted mid-transfer discards the held bundle.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept when in_valid && in_ready. The bundle is registered on that edge: latency 1 cycle, and out_valid = 1 the next cycle.
  - If out_valid && out_ready && !(in_valid && in_ready), out_valid clears next cycle.
  - While out_valid && !out_ready, all outputs hold stable.
- Register file:
  - 2 combinational read ports (rs1 = instr[19:15], rs2 = instr[24:20]) and 1 write port.
  - On wb_en, reg[wb_addr] <= wb_data, except when wb_addr == 0 (ignored).
  - x0 reads 0 always.
  - Write-through bypass: if wb_en && wb_addr == rsN && rsN != 0 in the accept cycle, the captured operand is wb_data.
  - Writebacks after acceptance do not modify an already-held bundle.
- Decode (opcode = instr[6:0], f3 = instr[14:12], f7 = instr[31:25]):
  - 0110011 R-type:
    - f3 000/f7 0000000 → add
    - f3 000/f7 0100000 → sub
    - f3 110/f7 0 → or
    - f3 111/f7 0 → and
    - data_2 = rs2; reg_write = 1.
  - 0010011 f3 000 (addi): add; data_2 = sext(instr[31:20]); reg_write = 1.
  - 0000011 f3 011 (ld): add; data_2 = sext(instr[31:20]); reg_write = 1; mem_read = 1.
  - 0100011 f3 011 (sd): add; data_2 = sext({instr[31:25], instr[11:7]}); store_data = rs2; mem_write = 1; reg_write = 0.
  - 1100011 f3 000 (beq): sub; data_2 = rs2; is_branch = 1; reg_write = 0.
  - rd_addr = instr[11:7] for R/I/load. It is 0 for store/branch.
  - Any other encoding: illegal = 1; reg_write, mem_read, mem_write and is_branch = 0; alu_op = 00; data_1 and data_2 = 0. It still occupies the output slot.
- Sign extension replicates bit 11 of the immediate into bits 63:12.
- reg_write is forced to 0 when rd == 0.

Test Plan:
- Reset, then write x5 = 0x10, x6 = 0x3 via wb; accept `add x7,x5,x6` → next cycle out_valid = 1, alu_op = 00, data_1 = 0x10, data_2 = 0x3, rd_addr = 7, reg_write = 1.
- Accept `sub x1,x5,x6` with out_ready = 0 for 3 cycles → outputs stable, in_ready = 0. Raise out_ready with a second instr present → back-to-back acceptance, no bubble.
- `addi x2,x0,-1` (imm 0xFFF) → data_1 = 0, data_2 = 0xFFFF_FFFF_FFFF_FFFF, alu_op = 00. `sd x6,-8(x5)` → data_2 = 0xFFFF_FFFF_FFFF_FFF8, store_data = 0x3, mem_write = 1, reg_write = 0.
- Bypass: wb_en = 1, wb_addr = 5, wb_data = 0xABCD in the same cycle as accepting `or x8,x5,x6` → data_1 = 0xABCD, alu_op = 10. wb to x0 with 0x55 → later read of x0 = 0.
- `beq x5,x5` → alu_op = 01, is_branch = 1; feed into the ALU → result 0. Encoding 0x0000_0000 → illegal = 1, reg_write = 0.
- Assert reset while out_valid = 1 and wb_en = 1 → next cycle out_valid = 0, all registers read 0, in_ready = 1.

Source files
------------

// File: rtl/operand_fetch_stage.sv
// rtl/operand_fetch_stage.sv - RV64I decode/register-read stage feeding the ALU
module operand_fetch_stage #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [1:0]      alu_op,
  output logic [XLEN-1:0] data_1,
  output logic [XLEN-1:0] data_2,
  output logic [XLEN-1:0] store_data,
  output logic [4:0]      rd_addr,
  output logic            reg_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            is_branch,
  output logic            illegal
);

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_OR  = 2'b10;
  localparam logic [1:0] ALU_AND = 2'b11;

  logic [XLEN-1:0] regs [NREGS];

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [4:0] rd;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic accept;

  logic            d_legal;
  logic [1:0]      d_op;
  logic [XLEN-1:0] d_d1;
  logic [XLEN-1:0] d_d2;
  logic [XLEN-1:0] d_sd;
  logic [4:0]      d_rd;
  logic            d_rw;
  logic            d_mr;
  logic            d_mw;
  logic            d_br;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign rd     = instr[11:7];
  assign imm_i  = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign imm_s  = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Read ports: x0 is hardwired to zero, a same-cycle writeback is forwarded
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (rs1 != 5'd0) begin
      rs1_val = (wb_en && wb_addr == rs1) ? wb_data : regs[rs1];
    end
    if (rs2 != 5'd0) begin
      rs2_val = (wb_en && wb_addr == rs2) ? wb_data : regs[rs2];
    end
  end

  // Decode the incoming instruction into the next output bundle
  always_comb begin
    d_legal = 1'b0;
    d_op    = ALU_ADD;
    d_d1    = rs1_val;
    d_d2    = '0;
    d_sd    = '0;
    d_rd    = '0;
    d_rw    = 1'b0;
    d_mr    = 1'b0;
    d_mw    = 1'b0;
    d_br    = 1'b0;
    case (opcode)
      OPC_R: begin
        d_d2 = rs2_val;
        d_rd = rd;
        d_rw = 1'b1;
        if (f7 == 7'b0000000 && f3 == 3'b000) begin
          d_legal = 1'b1;
          d_op    = ALU_ADD;
        end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
          d_legal = 1'b1;
          d_op    = ALU_SUB;
        end else if (f7 == 7'b0000000 && f3 == 3'b110) begin
          d_legal = 1'b1;
          d_op    = ALU_OR;
        end else if (f7 == 7'b0000000 && f3 == 3'b111) begin
          d_legal = 1'b1;
          d_op    = ALU_AND;
        end
      end
      OPC_I: begin
        d_legal = (f3 == 3'b000);
        d_d2    = imm_i;
        d_rd    = rd;
        d_rw    = 1'b1;
      end
      OPC_LOAD: begin
        d_legal = (f3 == 3'b011);
        d_d2    = imm_i;
        d_rd    = rd;
        d_rw    = 1'b1;
        d_mr    = 1'b1;
      end
      OPC_STORE: begin
        d_legal = (f3 == 3'b011);
        d_d2    = imm_s;
        d_sd    = rs2_val;
        d_mw    = 1'b1;
      end
      OPC_BRANCH: begin
        d_legal = (f3 == 3'b000);
        d_op    = ALU_SUB;
        d_d2    = rs2_val;
        d_br    = 1'b1;
      end
      default: d_legal = 1'b0;
    endcase
    // Writing x0 is architecturally a no-op, so never advertise it
    if (d_rd == 5'd0) begin
      d_rw = 1'b0;
    end
    // Unsupported encodings still occupy the slot but carry no side effects
    if (!d_legal) begin
      d_op = ALU_ADD;
      d_d1 = '0;
      d_d2 = '0;
      d_sd = '0;
      d_rd = '0;
      d_rw = 1'b0;
      d_mr = 1'b0;
      d_mw = 1'b0;
      d_br = 1'b0;
    end
  end

  // Register file write port; reset clears every entry
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_en && wb_addr != 5'd0) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // One-entry output register: load on accept, drain on consume, else hold
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      alu_op     <= '0;
      data_1     <= '0;
      data_2     <= '0;
      store_data <= '0;
      rd_addr    <= '0;
      reg_write  <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      is_branch  <= 1'b0;
      illegal    <= 1'b0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      alu_op     <= d_op;
      data_1     <= d_d1;
      data_2     <= d_d2;
      store_data <= d_sd;
      rd_addr    <= d_rd;
      reg_write  <= d_rw;
      mem_read   <= d_mr;
      mem_write  <= d_mw;
      is_branch  <= d_br;
      illegal    <= !d_legal;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule
